// File: rtl/cpu_data_mem_responder_pkg.sv
// Shared constants for the CPU data-port responder: MMIO placement,
// register offsets and STATUS bit positions.
package cpu_data_mem_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  localparam logic [15:0] OFF_CYCLES = 16'h0000;
  localparam logic [15:0] OFF_CMP    = 16'h0004;
  localparam logic [15:0] OFF_STATUS = 16'h0008;
  localparam logic [15:0] OFF_CTRL   = 16'h000C;

  localparam int ST_MATCH = 0;
  localparam int ST_ERR   = 1;

  // Sticky W1C update: a set in the same cycle as a clear wins.
  function automatic logic [1:0] status_next(input logic [1:0] cur,
                                             input logic [1:0] clr,
                                             input logic [1:0] set);
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/cpu_data_mem_responder_mmio_timer.sv
// Memory-mapped timer block: free-running CYCLES, CMP, CTRL and the sticky
// STATUS flags with match detection and write-1-to-clear.
module cpu_data_mem_responder_mmio_timer
  import cpu_data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] offset,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic        err_set,
  output logic [31:0] rdata,
  output logic        timer_irq,
  output logic        access_err
);

  logic [31:0] cycles_r;
  logic [31:0] cmp_r;
  logic        ctrl_r;
  logic [1:0]  status_r;
  logic [1:0]  set_s;
  logic [1:0]  clr_s;
  logic [31:0] rdata_s;

  // Flag set/clear requests for this cycle.
  always_comb begin
    set_s           = 2'b00;
    clr_s           = 2'b00;
    set_s[ST_MATCH] = ctrl_r & (cycles_r == cmp_r);
    set_s[ST_ERR]   = err_set;
    if (wr_en && (offset == OFF_STATUS)) begin
      clr_s = wdata[1:0];
    end else begin
      clr_s = 2'b00;
    end
  end

  // Register readback; unmapped offsets read zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (offset)
      OFF_CYCLES: rdata_s = cycles_r;
      OFF_CMP:    rdata_s = cmp_r;
      OFF_STATUS: rdata_s = {30'd0, status_r};
      OFF_CTRL:   rdata_s = {31'd0, ctrl_r};
      default:    rdata_s = 32'h0000_0000;
    endcase
  end

  // Register state; a CYCLES write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_r <= 32'h0000_0000;
      cmp_r    <= 32'h0000_0000;
      ctrl_r   <= 1'b0;
      status_r <= 2'b00;
    end else begin
      status_r <= status_next(status_r, clr_s, set_s);
      if (wr_en && (offset == OFF_CYCLES)) begin
        cycles_r <= wdata;
      end else begin
        cycles_r <= cycles_r + 32'd1;
      end
      if (wr_en && (offset == OFF_CMP)) begin
        cmp_r <= wdata;
      end
      if (wr_en && (offset == OFF_CTRL)) begin
        ctrl_r <= wdata[0];
      end
    end
  end

  assign rdata      = rdata_s;
  assign timer_irq  = status_r[ST_MATCH];
  assign access_err = status_r[ST_ERR];

endmodule

// File: rtl/cpu_data_mem_responder.sv
// Data-port responder for the single-cycle CPU: word RAM plus timer MMIO,
// zero-latency reads, writes committed on the clock edge.
module cpu_data_mem_responder
  import cpu_data_mem_responder_pkg::*;
#(
  parameter int          DEPTH     = 2048,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAdr,
  input  logic [31:0] memWriteData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] memReadData,
  output logic        timerIrq,
  output logic        accessErr
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram_r [DEPTH];
  logic          is_mmio_s;
  logic          in_ram_s;
  logic          legal_s;
  logic          err_s;
  logic          ram_we_s;
  logic          mmio_we_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   mmio_rdata_s;
  logic [31:0]   rdata_s;

  assign is_mmio_s = (memAdr[31:16] == MMIO_BASE[31:16]);
  assign in_ram_s  = (memAdr[31:AW+2] == {(30-AW){1'b0}});
  assign idx_s     = memAdr[AW+1:2];
  assign legal_s   = (memAdr[1:0] == 2'b00) && !(memRead && memWrite) &&
                     (in_ram_s || is_mmio_s);
  assign err_s     = (memRead || memWrite) && !legal_s;
  assign mmio_we_s = memWrite && legal_s && is_mmio_s;
  assign ram_we_s  = memWrite && legal_s && in_ram_s && !is_mmio_s;

  // Word RAM; contents survive reset but writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (!rst && ram_we_s) begin
      ram_r[idx_s] <= memWriteData;
    end
  end

  // Load data mux; zero when not reading or when the access is illegal.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (memRead && legal_s) begin
      if (is_mmio_s) begin
        rdata_s = mmio_rdata_s;
      end else begin
        rdata_s = ram_r[idx_s];
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  cpu_data_mem_responder_mmio_timer u_mmio_timer (
    .clk        (clk),
    .rst        (rst),
    .offset     (memAdr[15:0]),
    .wr_en      (mmio_we_s),
    .wdata      (memWriteData),
    .err_set    (err_s),
    .rdata      (mmio_rdata_s),
    .timer_irq  (timerIrq),
    .access_err (accessErr)
  );

  assign memReadData = rdata_s;

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// Self-checking bench: expected load data queued per driven cycle and
// compared once the combinational response settles; flags checked directly.
module tb_cpu_data_mem_responder;

  localparam int          DEPTH = 2048;
  localparam logic [31:0] MB    = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memAdr;
  logic [31:0] memWriteData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memReadData;
  logic        timerIrq;
  logic        accessErr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  cpu_data_mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .memAdr       (memAdr),
    .memWriteData (memWriteData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memReadData  (memReadData),
    .timerIrq     (timerIrq),
    .accessErr    (accessErr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, queue the expected load data, compare, advance past the edge.
  task automatic step(input string tag, input logic rs, input logic [31:0] adr,
                      input logic [31:0] wd, input logic rd, input logic wr,
                      input logic [31:0] exp);
    rst = rs; memAdr = adr; memWriteData = wd; memRead = rd; memWrite = wr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    check_eq(tag_q.pop_front(), memReadData, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] wd);
    step(tag, 1'b0, adr, wd, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    step(tag, 1'b0, adr, 32'h0, 1'b1, 1'b0, exp);
  endtask

  initial begin
    rst = 1'b1; memAdr = 32'h0; memWriteData = 32'h0; memRead = 1'b0; memWrite = 1'b0;
    @(posedge clk);
    #1;
    step("rst0", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("rst1", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("rst_irq", {31'd0, timerIrq}, 32'h0);
    check_eq("rst_err", {31'd0, accessErr}, 32'h0);

    // Counter from reset, then wrap.
    for (int i = 0; i < 3; i++) rd("cyc_start", MB, i);
    wr("cyc_load", MB, 32'hFFFF_FFFE);
    rd("cyc_fe", MB, 32'hFFFF_FFFE);
    rd("cyc_ff", MB, 32'hFFFF_FFFF);
    rd("cyc_wrap", MB, 32'h0000_0000);

    // RAM write/read and overwrite.
    wr("ram_w1", 32'h10, 32'h1111_1111);
    rd("ram_r1", 32'h10, 32'h1111_1111);
    wr("ram_w2", 32'h10, 32'hDEAD_BEEF);
    rd("ram_r2", 32'h10, 32'hDEAD_BEEF);

    // Misaligned store.
    wr("mis_w", 32'h13, 32'h1234_5678);
    check_eq("mis_err", {31'd0, accessErr}, 32'h1);
    wr("err_clr", MB + 32'h8, 32'h2);
    check_eq("err_clr", {31'd0, accessErr}, 32'h0);
    rd("mis_ram", 32'h10, 32'hDEAD_BEEF);

    // Timer match at CYCLES==20.
    wr("cmp_w", MB + 32'h4, 32'd20);
    wr("ctrl_w", MB + 32'hC, 32'h1);
    wr("cyc_zero", MB, 32'h0);
    for (int i = 0; i <= 20; i++) begin
      rd("tm_cyc", MB, i);
      if (i == 19) check_eq("tm_irq_pre", {31'd0, timerIrq}, 32'h0);
    end
    check_eq("tm_irq", {31'd0, timerIrq}, 32'h1);

    // W1C colliding with a fresh match keeps the flag; a lone W1C clears it.
    wr("cyc18", MB, 32'd18);
    rd("c18", MB, 32'd18);
    rd("c19", MB, 32'd19);
    wr("w1c_hit", MB + 32'h8, 32'h1);
    check_eq("set_wins", {31'd0, timerIrq}, 32'h1);
    wr("w1c", MB + 32'h8, 32'h1);
    check_eq("w1c_irq", {31'd0, timerIrq}, 32'h0);

    // Timer disabled: no match; CTRL upper bits ignored.
    wr("ctrl_off", MB + 32'hC, 32'hFFFF_FFFE);
    wr("cyc18b", MB, 32'd18);
    for (int i = 18; i < 22; i++) rd("off_cyc", MB, i);
    check_eq("off_irq", {31'd0, timerIrq}, 32'h0);
    rd("ctrl_rd", MB + 32'hC, 32'h0);

    // Conflicts and address range.
    wr("w20", 32'h20, 32'h0BAD_F00D);
    step("rw_both", 1'b0, 32'h20, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0);
    check_eq("rw_err", {31'd0, accessErr}, 32'h1);
    rd("rw_ram", 32'h20, 32'h0BAD_F00D);
    wr("err_clr2", MB + 32'h8, 32'h2);
    check_eq("err_clr2", {31'd0, accessErr}, 32'h0);
    rd("mmio_hole", MB + 32'h40, 32'h0);
    check_eq("hole_err", {31'd0, accessErr}, 32'h0);
    rd("oor", DEPTH * 4, 32'h0);
    check_eq("oor_err", {31'd0, accessErr}, 32'h1);
    rd("stat_err", MB + 32'h8, 32'h2);

    // Build STATUS=3 then reset in the middle of a store.
    wr("cmp7", MB + 32'h4, 32'd7);
    wr("ctrl_on", MB + 32'hC, 32'h1);
    wr("cyc5", MB, 32'd5);
    for (int i = 5; i <= 7; i++) rd("c57", MB, i);
    check_eq("irq7", {31'd0, timerIrq}, 32'h1);
    rd("stat3", MB + 32'h8, 32'h3);
    wr("w30", 32'h30, 32'h4444_4444);
    step("rst_st", 1'b1, 32'h30, 32'h5555_5555, 1'b0, 1'b1, 32'h0);
    check_eq("rst_irq2", {31'd0, timerIrq}, 32'h0);
    check_eq("rst_err2", {31'd0, accessErr}, 32'h0);
    rd("rst_cyc0", MB, 32'h0);
    rd("rst_cyc1", MB, 32'h1);
    rd("rst_ram", 32'h30, 32'h4444_4444);
    rd("rst_stat", MB + 32'h8, 32'h0);
    rd("rst_ctrl", MB + 32'hC, 32'h0);
    rd("rst_cmp", MB + 32'h4, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
